// File: rtl/snn_inference_ctrl.sv
// Sequences one spiking-network inference over N_STEPS timesteps and reports per-neuron spike counts plus argmax.
// Optional watchdog: define SNN_CTRL_TIMEOUT_EN to enable the TIMEOUT-cycle ISSUE/RUN watchdog and the error flag.
module snn_inference_ctrl #(
  parameter int N_IN    = 4,
  parameter int N_OUT   = 2,
  parameter int N_STEPS = 10,
  parameter int CNT_W   = 5,
  parameter int TIMEOUT = 64,
  localparam int CLS_W  = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   in_valid,
  input  logic [N_IN-1:0]        in_spikes,
  output logic                   in_ready,
  output logic                   net_start,
  output logic                   net_sample_ready,
  output logic [N_IN-1:0]        net_in_spikes,
  input  logic                   net_sample,
  input  logic                   net_ready,
  input  logic [N_OUT-1:0]       net_out_spikes,
  output logic                   busy,
  output logic                   result_valid,
  input  logic                   result_ready,
  output logic [CLS_W-1:0]       result_class,
  output logic [N_OUT*CNT_W-1:0] result_counts,
  output logic                   error
);

  typedef enum logic [2:0] {IDLE, FETCH, ISSUE, RUN, DONE} state_t;

  // Step counter is widened when CNT_W is too narrow to reach N_STEPS-1.
  localparam int STEP_W = ($clog2(N_STEPS + 1) > CNT_W) ? $clog2(N_STEPS + 1) : CNT_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t                 state, state_nxt;
  logic [N_IN-1:0]        buffer;
  logic [CNT_W-1:0]       cnt     [N_OUT];
  logic [CNT_W-1:0]       cnt_nxt [N_OUT];
  logic [N_OUT*CNT_W-1:0] cnt_flat;
  logic [STEP_W-1:0]      step_cnt;
  logic                   run_first;
  logic                   count_en;
  logic                   last_step;
  logic                   timeout_hit;
  logic [CLS_W-1:0]       argmax;
  logic [CNT_W-1:0]       best;

  assign in_ready         = (state == FETCH);
  assign net_sample_ready = (state == ISSUE);
  assign net_in_spikes    = (state == ISSUE) ? buffer : '0;
  assign busy             = (state == FETCH) || (state == ISSUE) || (state == RUN);
  assign net_start        = busy;
  assign result_valid     = (state == DONE);

  assign count_en  = (state == RUN) && !run_first && net_ready;
  assign last_step = (step_cnt == STEP_W'(N_STEPS - 1));

  // Saturating next-count values; argmax sees the final step's increments.
  always_comb begin
    cnt_flat = '0;
    for (int i = 0; i < N_OUT; i++) begin
      cnt_nxt[i] = cnt[i];
      if (count_en && net_out_spikes[i] && (cnt[i] != CNT_MAX))
        cnt_nxt[i] = cnt[i] + 1'b1;
      cnt_flat[i*CNT_W +: CNT_W] = cnt_nxt[i];
    end
  end

  always_comb begin
    best   = cnt_nxt[0];
    argmax = '0;
    for (int i = 1; i < N_OUT; i++) begin
      if (cnt_nxt[i] > best) begin
        best   = cnt_nxt[i];
        argmax = CLS_W'(i);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = FETCH;
      FETCH: if (in_valid) state_nxt = ISSUE;
      ISSUE: if (net_sample) state_nxt = RUN;
      RUN:   if (count_en) state_nxt = last_step ? DONE : FETCH;
      DONE:  if (result_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (timeout_hit) state_nxt = DONE;
    if (abort) state_nxt = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      buffer        <= '0;
      step_cnt      <= '0;
      run_first     <= 1'b0;
      result_counts <= '0;
      result_class  <= '0;
      for (int i = 0; i < N_OUT; i++) cnt[i] <= '0;
    end else begin
      state     <= state_nxt;
      run_first <= (state == ISSUE);
      if (!abort && (state == FETCH) && in_valid) buffer <= in_spikes;
      if (abort || ((state == IDLE) && start)) begin
        step_cnt <= '0;
        for (int i = 0; i < N_OUT; i++) cnt[i] <= '0;
      end else if (count_en) begin
        step_cnt <= step_cnt + 1'b1;
        for (int i = 0; i < N_OUT; i++) cnt[i] <= cnt_nxt[i];
      end
      if ((state_nxt == DONE) && (state != DONE)) begin
        result_counts <= cnt_flat;
        result_class  <= argmax;
      end
    end
  end

`ifdef SNN_CTRL_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);

  logic [WD_W-1:0] wd;
  logic            wd_active;

  assign wd_active   = (state == ISSUE) || (state == RUN);
  // Fires only when the current state would otherwise stay put.
  assign timeout_hit = wd_active && (wd == WD_W'(TIMEOUT - 1)) &&
                       !((state == ISSUE) && net_sample) && !count_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd    <= '0;
      error <= 1'b0;
    end else begin
      if (abort || ((state == IDLE) && start)) error <= 1'b0;
      else if (timeout_hit)                    error <= 1'b1;
      if ((state_nxt != state) && ((state_nxt == ISSUE) || (state_nxt == RUN))) wd <= '0;
      else if (wd_active)                                                        wd <= wd + 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign error       = 1'b0;
`endif

endmodule

// File: tb/tb_snn_inference_ctrl.sv
// Scoreboard bench for snn_inference_ctrl: a second instance with CNT_W=3 runs in lockstep to cover saturation.
module tb_snn_inference_ctrl;

  logic       clk = 1'b0;
  logic       rst, start, abort, in_valid, net_sample, net_ready, result_ready;
  logic [3:0] in_spikes;
  logic [1:0] net_out_spikes;

  logic       in_ready, net_start, net_sample_ready, busy, result_valid, error;
  logic [3:0] net_in_spikes;
  logic [0:0] result_class;
  logic [9:0] result_counts;

  logic       b_in_ready, b_net_start, b_net_sample_ready, b_busy, b_result_valid, b_error;
  logic [3:0] b_net_in_spikes;
  logic [0:0] b_result_class;
  logic [5:0] b_result_counts;

  always #5 clk = ~clk;

  snn_inference_ctrl #(.N_IN(4), .N_OUT(2), .N_STEPS(10), .CNT_W(5), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .in_valid(in_valid), .in_spikes(in_spikes), .in_ready(in_ready),
    .net_start(net_start), .net_sample_ready(net_sample_ready), .net_in_spikes(net_in_spikes),
    .net_sample(net_sample), .net_ready(net_ready), .net_out_spikes(net_out_spikes),
    .busy(busy), .result_valid(result_valid), .result_ready(result_ready),
    .result_class(result_class), .result_counts(result_counts), .error(error)
  );

  snn_inference_ctrl #(.N_IN(4), .N_OUT(2), .N_STEPS(10), .CNT_W(3), .TIMEOUT(16)) dut_sat (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .in_valid(in_valid), .in_spikes(in_spikes), .in_ready(b_in_ready),
    .net_start(b_net_start), .net_sample_ready(b_net_sample_ready), .net_in_spikes(b_net_in_spikes),
    .net_sample(net_sample), .net_ready(net_ready), .net_out_spikes(net_out_spikes),
    .busy(b_busy), .result_valid(b_result_valid), .result_ready(result_ready),
    .result_class(b_result_class), .result_counts(b_result_counts), .error(b_error)
  );

  typedef struct {int c0; int c1; int cls; int b0; int b1; int bcls;} res_t;

  res_t       exp_res[$];
  logic [3:0] exp_vec[$];
  res_t       mon_r;
  logic       prev_nsr = 1'b0;
  logic [1:0] pat [10];
  int         n_cmp = 0, n_bad = 0;
  int         sample_delay = 0, net_step = 0, net_dly = 0, hs_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic res_t mk(input int c0, input int c1, input int cls,
                              input int b0, input int b1, input int bcls);
    res_t r;
    r.c0 = c0; r.c1 = c1; r.cls = cls; r.b0 = b0; r.b1 = b1; r.bcls = bcls;
    return r;
  endfunction

  // Network model: pulses net_sample after sample_delay ISSUE cycles and presents that step's spikes.
  initial begin
    net_sample = 1'b0;
    net_out_spikes = 2'b00;
    forever begin
      @(negedge clk);
      if (net_sample_ready && !net_sample) begin
        if (net_dly < sample_delay) net_dly++;
        else begin
          net_sample = 1'b1;
          net_out_spikes = pat[net_step % 10];
          net_step++;
          net_dly = 0;
        end
      end else begin
        net_sample = 1'b0;
        if (!net_sample_ready) net_dly = 0;
      end
    end
  end

  // Monitor: checks the issued vector every ISSUE cycle and each result at its handshake.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (net_sample_ready) begin
        if (exp_vec.size() == 0) check("vec_expected", 0, 1);
        else check("net_in_spikes", net_in_spikes, exp_vec[0]);
      end
      if (prev_nsr && !net_sample_ready && exp_vec.size() > 0) void'(exp_vec.pop_front());
      prev_nsr = net_sample_ready;
      if (result_valid && result_ready) begin
        if (exp_res.size() == 0) check("unexpected_result", 1, 0);
        else begin
          mon_r = exp_res.pop_front();
          check("count0", result_counts[4:0], mon_r.c0);
          check("count1", result_counts[9:5], mon_r.c1);
          check("class", result_class, mon_r.cls);
          check("sat_count0", b_result_counts[2:0], mon_r.b0);
          check("sat_count1", b_result_counts[5:3], mon_r.b1);
          check("sat_class", b_result_class, mon_r.bcls);
        end
      end
    end
  end

  task automatic send(input logic [3:0] v, input int gap);
    int g;
    in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    in_valid = 1'b1;
    in_spikes = v;
    g = 0;
    while (!in_ready && g < 300) begin
      @(negedge clk);
      g++;
    end
    if (!in_ready) begin
      check("fetch_wait", 0, 1);
      in_valid = 1'b0;
      return;
    end
    exp_vec.push_back(v);
    hs_cnt++;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic run(input logic [3:0] fixed_v, input bit use_fixed, input int gap,
                     input int rr_delay, input bit poke_start, input int abort_step, input res_t r);
    int g;
    net_step = 0;
    hs_cnt = 0;
    if (abort_step < 0) exp_res.push_back(r);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int s = 0; s < 10; s++) begin
      if (poke_start && s == 2) begin
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
      send(use_fixed ? fixed_v : 4'(s * 3 + 5), gap);
      if (s == abort_step) begin
        g = 0;
        while (!(busy && !in_ready && !net_sample_ready) && g < 50) begin
          @(negedge clk);
          g++;
        end
        check("reach_run", busy && !in_ready && !net_sample_ready, 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_in_ready", in_ready, 0);
        check("abort_result_valid", result_valid, 0);
        check("abort_net_start", net_start, 0);
        return;
      end
    end
    check("handshakes", hs_cnt, 10);
    g = 0;
    while (!result_valid && g < 300) begin
      @(negedge clk);
      g++;
    end
    check("result_valid_seen", result_valid, 1);
    check("done_busy", busy, 0);
    check("done_net_start", net_start, 0);
    for (int i = 0; i < rr_delay; i++) begin
      if (poke_start && i == 1) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("result_hold", result_valid, 1);
    end
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
    check("idle_after_result", result_valid, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0; in_spikes = 4'h0;
    net_ready = 1'b1; result_ready = 1'b0;
    for (int i = 0; i < 10; i++) pat[i] = 2'b00;
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_net_start", net_start, 0);
    check("rst_net_sample_ready", net_sample_ready, 0);
    check("rst_net_in_spikes", net_in_spikes, 0);
    check("rst_result_valid", result_valid, 0);
    check("rst_result_class", result_class, 0);
    check("rst_result_counts", result_counts, 0);
    check("rst_error", error, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 10; i++) pat[i] = 2'b01;
    run(4'hF, 1'b1, 0, 0, 1'b0, -1, mk(10, 0, 0, 7, 0, 0));

    for (int i = 0; i < 10; i++) pat[i] = (i % 2 == 0) ? 2'b01 : 2'b10;
    run(4'h0, 1'b0, 0, 0, 1'b0, -1, mk(5, 5, 0, 5, 5, 0));

    for (int i = 0; i < 10; i++) pat[i] = 2'b10;
    run(4'h0, 1'b0, 0, 0, 1'b0, -1, mk(0, 10, 1, 0, 7, 1));

    for (int i = 0; i < 10; i++) pat[i] = 2'b11;
    run(4'h0, 1'b0, 0, 0, 1'b0, -1, mk(10, 10, 0, 7, 7, 0));

    // Backpressure; saturation turns a class-1 win into a 7/7 tie on the narrow instance.
    for (int i = 0; i < 10; i++) pat[i] = (i < 8) ? 2'b11 : 2'b10;
    sample_delay = 3;
    run(4'h0, 1'b0, 5, 4, 1'b1, -1, mk(8, 10, 1, 7, 7, 0));
    sample_delay = 0;

    for (int i = 0; i < 10; i++) pat[i] = 2'b01;
    run(4'h0, 1'b0, 0, 0, 1'b0, 4, mk(0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 10; i++) pat[i] = (i < 7) ? 2'b10 : 2'b01;
    run(4'h0, 1'b0, 0, 0, 1'b0, -1, mk(3, 7, 1, 3, 7, 1));

    sample_delay = 1000;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    send(4'hA, 0);
    check("issue_reached", net_sample_ready, 1);
    #2 rst = 1'b1;
    #1;
    check("arst_in_ready", in_ready, 0);
    check("arst_busy", busy, 0);
    check("arst_net_start", net_start, 0);
    check("arst_net_sample_ready", net_sample_ready, 0);
    check("arst_net_in_spikes", net_in_spikes, 0);
    check("arst_result_valid", result_valid, 0);
    check("arst_error", error, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    send(4'h6, 0);
`ifdef SNN_CTRL_TIMEOUT_EN
    exp_res.push_back(mk(0, 0, 0, 0, 0, 0));
    repeat (16) @(negedge clk);
    check("wd_result_valid", result_valid, 1);
    check("wd_error", error, 1);
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
    check("wd_error_held", error, 1);
`else
    repeat (40) @(negedge clk);
    check("stuck_in_issue", net_sample_ready, 1);
    check("stuck_error", error, 0);
    check("stuck_no_result", result_valid, 0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("stuck_abort_idle", busy, 0);
`endif
    sample_delay = 0;
    repeat (3) @(negedge clk);
    check("results_drained", exp_res.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/snn_inference_ctrl.md
Name: snn_inference_ctrl

Overview:
- Sequences one spiking-network inference over N_STEPS timesteps. Fetches input spike vectors from an upstream source through a valid/ready handshake and presents each one to the `network` core using its start/sample/sample_ready/ready protocol.
- Accumulates per-neuron output spike counts across the window and reports an argmax class.
- Sits between the input encoder / stimulus FIFO and the `network` instance.

Parameters:
- N_IN, 4, input spike vector width (matches network in_spikes)
- N_OUT, 2, output neuron count (matches network out_spikes)
- N_STEPS, 10, timesteps per inference, >=1
- CNT_W, 5, width of each output spike counter and of the step counter
- TIMEOUT, 64, watchdog limit in cycles (used only with the optional feature)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request to begin an inference; honoured only in IDLE
- abort  in  1  synchronous abort; returns to IDLE from any state
- in_valid  in  1  upstream spike vector valid
- in_spikes  in  N_IN  upstream spike vector
- in_ready  out  1  controller accepts in_spikes
- net_start  out  1  to network start
- net_sample_ready  out  1  to network sample_ready; a buffered vector is available
- net_in_spikes  out  N_IN  to network in_spikes
- net_sample  in  1  network pulse: current net_in_spikes consumed
- net_ready  in  1  network timestep complete, out_spikes valid
- net_out_spikes  in  N_OUT  network output spikes
- busy  out  1  inference in progress
- result_valid  out  1  result available
- result_ready  in  1  downstream accepts result
- result_class  out  $clog2(N_OUT) (min 1)  argmax neuron index
- result_counts  out  N_OUT*CNT_W  per-neuron counts; neuron i occupies bits [i*CNT_W +: CNT_W]
- error  out  1  watchdog fired (always 0 without the optional feature)

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high.
- Reset values: state IDLE, all outputs 0, counters and buffer 0.
- All outputs are registered or decoded from the state register. No combinational path from inputs to outputs.
- IDLE: busy=0.
  - start=1 → clear counters, step_cnt and error; next state FETCH.
- FETCH: in_ready=1, net_start=1, busy=1.
  - in_valid&in_ready → latch in_spikes into the buffer; next state ISSUE.
  - No acceptance occurs in any other state.
- ISSUE: net_sample_ready=1, net_in_spikes=buffer, net_start=1.
  - net_sample=1 → next state RUN. The buffer holds until that transition.
- RUN: net_start=1.
  - net_ready is ignored in the first RUN cycle.
  - From the second cycle on, net_ready=1 → for each i with net_out_spikes[i]=1, count[i] increments, saturating at 2^CNT_W-1; step_cnt increments.
  - If step_cnt was N_STEPS-1 → DONE, else → FETCH.
- DONE: result_valid=1, busy=0, net_start=0.
  - result_counts and result_class are held stable.
  - result_valid&result_ready → IDLE. start is ignored in DONE.
- Argmax:
  - Computed combinationally from the counters and registered on entry to DONE.
  - Ties resolve to the lowest index. All counts zero gives class 0.
- Latency: minimum 4 cycles per timestep (FETCH, ISSUE, 2×RUN) with always-ready neighbours.
- Boundary conditions:
  - start while busy: ignored.
  - abort: wins over every other event in the same cycle. Next state IDLE; result_valid, net_sample_ready and in_ready drop next cycle; counters cleared.
  - rst mid-inference: immediate return to the reset values.
  - Counter saturation: a counter holds at max with no wrap. result_class still reflects the saturated values.
  - N_STEPS=1: DONE after the first RUN completion.

Optional Feature:
- Macro: SNN_CTRL_TIMEOUT_EN.
- Defined:
  - A watchdog counter clears on every entry to ISSUE or RUN and increments each cycle spent in those states.
  - Reaching TIMEOUT → error=1, state DONE with the current partial counts.
  - error holds until the next accepted start or abort/rst.
- Undefined: no watchdog logic; error is tied to 0; ISSUE and RUN wait indefinitely.

Test Plan:
- Nominal run: N_STEPS=10; in_spikes=4'hF every step; network returns out_spikes=2'b01 each step → result_valid with counts {0,10}, result_class=0, 10 in_valid/in_ready handshakes.
- Tie and argmax: out_spikes alternates 2'b01/2'b10 over 10 steps → counts 5/5, result_class=0. All 2'b10 → class 1, count[1]=10.
- Saturation: CNT_W=3, N_STEPS=10, out_spikes=2'b11 each step → both counts 7, class 0, no wrap.
- Backpressure: in_valid low for 5 cycles in FETCH, net_sample delayed 3 cycles, result_ready delayed 4 cycles.
  - Expect net_in_spikes stable throughout ISSUE.
  - Expect the result held with result_valid=1 until the handshake.
  - Expect start pulses during busy or DONE to be ignored.
- Abort/reset: abort in RUN at step 4 → IDLE next cycle, counters 0; a new start then gives correct full-window counts. rst asserted mid-ISSUE → all outputs 0 asynchronously.
- SNN_CTRL_TIMEOUT_EN, TIMEOUT=16: net_sample never asserted → error=1 and result_valid=1 after 16 ISSUE cycles. Without the macro, the controller stays in ISSUE.
